// File: rtl/ram_nr1w_fwd.sv
// n-read / 1-write synchronous RAM with byte write mask, registered read ports,
// configurable read-during-write forwarding and a post-reset zero-fill engine.
module ram_nr1w_fwd #(
  parameter int MEMD       = 512,
  parameter int DATAW      = 32,
  parameter int NUM_WMASKS = DATAW / 8,
  parameter int nRPORTS    = 2,
  parameter int ADDRW      = 9,
  parameter int RDW_MODE   = 1,
  parameter int INIT_ZERO  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       init_done,
  input  logic                       wen,
  input  logic [ADDRW-1:0]           waddr,
  input  logic [NUM_WMASKS-1:0]      wmask,
  input  logic [DATAW-1:0]           wdata,
  input  logic [nRPORTS-1:0]         ren,
  input  logic [ADDRW*nRPORTS-1:0]   raddr,
  output logic [DATAW*nRPORTS-1:0]   rdata,
  output logic [nRPORTS-1:0]         rvalid,
  output logic [15:0]                rdw_cnt
);

  localparam logic [ADDRW:0]   MEMD_W    = (ADDRW + 1)'(MEMD);
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(MEMD - 1);

  typedef enum logic {ST_FILL, ST_IDLE} state_t;

  logic [DATAW-1:0]      r_mem [MEMD];
  state_t                r_state;
  logic [ADDRW-1:0]      r_fillCnt;
  logic                  r_initDone;
  logic [DATAW-1:0]      r_rdata [nRPORTS];
  logic [nRPORTS-1:0]    r_rvalid;
  logic [15:0]           r_rdwCnt;

  logic                  w_wInRange;
  logic                  w_wAccept;
  logic [DATAW-1:0]      w_byteMask;
  logic                  w_memWe;
  logic [ADDRW-1:0]      w_memAddr;
  logic [DATAW-1:0]      w_memData;
  logic [NUM_WMASKS-1:0] w_memByteEn;
  logic [ADDRW-1:0]      w_raddr [nRPORTS];
  logic [DATAW-1:0]      w_rOld  [nRPORTS];
  logic [DATAW-1:0]      w_rWord [nRPORTS];
  logic [nRPORTS-1:0]    w_hit;
  logic [4:0]            w_rdwInc;
  logic [16:0]           w_rdwSum;

  assign w_wInRange = ({1'b0, waddr} < MEMD_W);
  assign w_wAccept  = wen & r_initDone & w_wInRange;

  always_comb begin
    w_byteMask = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      w_byteMask[8*i +: 8] = {8{wmask[i]}};
    end
  end

  // The fill engine owns the single write port until the array is cleared.
  always_comb begin
    w_memWe     = 1'b0;
    w_memAddr   = waddr;
    w_memData   = wdata;
    w_memByteEn = wmask;
    if (!rst) begin
      if (r_state == ST_FILL) begin
        w_memWe     = 1'b1;
        w_memAddr   = r_fillCnt;
        w_memData   = '0;
        w_memByteEn = '1;
      end else if (w_wAccept) begin
        w_memWe = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_memWe) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (w_memByteEn[i]) begin
          r_mem[w_memAddr][8*i +: 8] <= w_memData[8*i +: 8];
        end
      end
    end
  end

  // Per-port read word, with optional forwarding of the byte-merged write data.
  always_comb begin
    w_rdwInc = '0;
    w_hit    = '0;
    for (int p = 0; p < nRPORTS; p++) begin
      w_raddr[p] = raddr[ADDRW*p +: ADDRW];
      w_rOld[p]  = ({1'b0, w_raddr[p]} < MEMD_W) ? r_mem[w_raddr[p]] : '0;
      w_hit[p]   = ren[p] & w_wAccept & (w_raddr[p] == waddr);
      if ((RDW_MODE == 1) && w_hit[p]) begin
        w_rWord[p] = (w_rOld[p] & ~w_byteMask) | (wdata & w_byteMask);
      end else begin
        w_rWord[p] = w_rOld[p];
      end
      w_rdwInc = w_rdwInc + {4'b0, w_hit[p]};
    end
  end

  assign w_rdwSum = {1'b0, r_rdwCnt} + 17'(w_rdwInc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= (INIT_ZERO != 0) ? ST_FILL : ST_IDLE;
      r_fillCnt  <= '0;
      r_initDone <= 1'b0;
      r_rvalid   <= '0;
      r_rdwCnt   <= '0;
      for (int p = 0; p < nRPORTS; p++) begin
        r_rdata[p] <= '0;
      end
    end else begin
      case (r_state)
        ST_FILL: begin
          r_fillCnt <= r_fillCnt + 1'b1;
          if (r_fillCnt == LAST_ADDR) begin
            r_state    <= ST_IDLE;
            r_initDone <= 1'b1;
          end
        end
        default: r_initDone <= 1'b1;
      endcase
      for (int p = 0; p < nRPORTS; p++) begin
        r_rvalid[p] <= ren[p] & r_initDone;
        if (ren[p] && r_initDone) begin
          r_rdata[p] <= w_rWord[p];
        end
      end
      r_rdwCnt <= w_rdwSum[16] ? 16'hFFFF : w_rdwSum[15:0];
    end
  end

  genvar g;
  generate
    for (g = 0; g < nRPORTS; g++) begin : g_rdata
      assign rdata[DATAW*g +: DATAW] = r_rdata[g];
    end
  endgenerate

  assign init_done = r_initDone;
  assign rvalid    = r_rvalid;
  assign rdw_cnt   = r_rdwCnt;

endmodule

// File: tb/tb_ram_nr1w_fwd.sv
// Scoreboard bench for ram_nr1w_fwd: forwarding instance (A), old-data instance (B)
// and a non-power-of-two depth instance (C), all driven by the same stimulus.
module tb_ram_nr1w_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [8:0]  waddr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [1:0]  ren;
  logic [17:0] raddr;

  logic        aInitDone, bInitDone, cInitDone;
  logic [63:0] aRdata, bRdata, cRdata;
  logic [1:0]  aRvalid, bRvalid, cRvalid;
  logic [15:0] aRdwCnt, bRdwCnt, cRdwCnt;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] model [512];
  bit          modelReady = 1'b0;
  int          modelRdw   = 0;
  logic [31:0] expQ0 [$];
  logic [31:0] expQ1 [$];
  logic [31:0] monExp;
  bit          monHave;

  always #5 clk = ~clk;

  ram_nr1w_fwd #(.MEMD(512), .ADDRW(9), .RDW_MODE(1)) dutA (
    .clk(clk), .rst(rst), .init_done(aInitDone), .wen(wen), .waddr(waddr),
    .wmask(wmask), .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(aRdata),
    .rvalid(aRvalid), .rdw_cnt(aRdwCnt));

  ram_nr1w_fwd #(.MEMD(512), .ADDRW(9), .RDW_MODE(0)) dutB (
    .clk(clk), .rst(rst), .init_done(bInitDone), .wen(wen), .waddr(waddr),
    .wmask(wmask), .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(bRdata),
    .rvalid(bRvalid), .rdw_cnt(bRdwCnt));

  ram_nr1w_fwd #(.MEMD(500), .ADDRW(9), .RDW_MODE(1)) dutC (
    .clk(clk), .rst(rst), .init_done(cInitDone), .wen(wen), .waddr(waddr),
    .wmask(wmask), .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(cRdata),
    .rvalid(cRvalid), .rdw_cnt(cRdwCnt));

  // Every valid read from instance A must match the oldest expectation for that port.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 2; p++) begin
      if (aRvalid[p] === 1'b1) begin
        checkCount++;
        monHave = (p == 0) ? (expQ0.size() > 0) : (expQ1.size() > 0);
        if (!monHave) begin
          $display("[TB] FAIL unexpected_rvalid port%0d: got rvalid=1 expected rvalid=0", p);
        end else begin
          monExp = (p == 0) ? expQ0.pop_front() : expQ1.pop_front();
          if (aRdata[32*p +: 32] !== monExp)
            $display("[TB] FAIL read_port%0d: got %08h expected %08h", p, aRdata[32*p +: 32], monExp);
          else
            passCount++;
        end
      end
    end
  end

  function automatic logic [31:0] mergeWord(input logic [31:0] oldW, input logic [31:0] newW,
                                            input logic [3:0] m);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = m[i] ? newW[8*i +: 8] : oldW[8*i +: 8];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iWen, input logic [8:0] iWaddr, input logic [3:0] iWmask,
                       input logic [31:0] iWdata, input logic [1:0] iRen,
                       input logic [8:0] iRa0, input logic [8:0] iRa1);
    logic [8:0]  ra;
    logic [31:0] expWord;
    wen = iWen; waddr = iWaddr; wmask = iWmask; wdata = iWdata;
    ren = iRen; raddr = {iRa1, iRa0};
    if (modelReady) begin
      for (int p = 0; p < 2; p++) begin
        ra = (p == 0) ? iRa0 : iRa1;
        if (iRen[p]) begin
          expWord = model[ra];
          if (iWen && (ra == iWaddr)) begin
            expWord = mergeWord(model[ra], iWdata, iWmask);
            modelRdw++;
          end
          if (p == 0) expQ0.push_back(expWord); else expQ1.push_back(expWord);
        end
      end
      if (modelRdw > 65535) modelRdw = 65535;
      if (iWen) model[iWaddr] = mergeWord(model[iWaddr], iWdata, iWmask);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b0; waddr = '0; wmask = '0; wdata = '0; ren = '0; raddr = '0;
    tick(); tick();
    checkCount++; if (aInitDone !== 1'b0) $display("[TB] FAIL reset_init_done: got %b expected 0", aInitDone); else passCount++;
    checkCount++; if (aRvalid !== 2'b00) $display("[TB] FAIL reset_rvalid: got %b expected 00", aRvalid); else passCount++;
    checkCount++; if (aRdata !== 64'h0) $display("[TB] FAIL reset_rdata: got %h expected 0", aRdata); else passCount++;
    checkCount++; if (aRdwCnt !== 16'h0) $display("[TB] FAIL reset_rdw_cnt: got %h expected 0", aRdwCnt); else passCount++;
    checkCount++; if (cInitDone !== 1'b0) $display("[TB] FAIL reset_init_done_c: got %b expected 0", cInitDone); else passCount++;
  endtask

  task automatic test_fill();
    int riseA = -1;
    int riseC = -1;
    rst = 1'b0;
    ren = 2'b11;
    for (int n = 1; n <= 700 && riseA < 0; n++) begin
      raddr = {9'($urandom_range(0, 511)), 9'($urandom_range(0, 511))};
      tick();
      if (aInitDone === 1'b1 && riseA < 0) riseA = n;
      if (cInitDone === 1'b1 && riseC < 0) riseC = n;
    end
    ren = 2'b00;
    checkCount++; if (riseA !== 512) $display("[TB] FAIL fill_latency_512: got %0d expected 512", riseA); else passCount++;
    checkCount++; if (riseC !== 500) $display("[TB] FAIL fill_latency_500: got %0d expected 500", riseC); else passCount++;
    modelReady = 1'b1;
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b11, 9'd0, 9'd255);
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b01, 9'd511, 9'd0);
    checkCount++; if (aRdata[31:0] !== 32'h0 || aRvalid !== 2'b01) $display("[TB] FAIL fill_read_511: got %h/%b expected 0/01", aRdata[31:0], aRvalid); else passCount++;
  endtask

  task automatic test_masked_write();
    drive(1'b1, 9'd5, 4'b1111, 32'hAABBCCDD, 2'b00, 9'd0, 9'd0);
    drive(1'b1, 9'd5, 4'b0101, 32'h11223344, 2'b00, 9'd0, 9'd0);
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b01, 9'd5, 9'd0);
    checkCount++; if (aRdata[31:0] !== 32'hAA22CC44) $display("[TB] FAIL masked_write: got %h expected aa22cc44", aRdata[31:0]); else passCount++;
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b00, 9'd0, 9'd0);
    checkCount++; if (aRvalid !== 2'b00 || aRdata[31:0] !== 32'hAA22CC44) $display("[TB] FAIL rdata_hold: got %h/%b expected aa22cc44/00", aRdata[31:0], aRvalid); else passCount++;
    drive(1'b1, 9'd5, 4'b0000, 32'hFFFFFFFF, 2'b00, 9'd0, 9'd0);
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b11, 9'd5, 9'd5);
    checkCount++; if (aRdata !== {2{32'hAA22CC44}}) $display("[TB] FAIL zero_mask_dual_read: got %h expected aa22cc44aa22cc44", aRdata); else passCount++;
  endtask

  task automatic test_rdw();
    int prevRdw;
    drive(1'b1, 9'd7, 4'b1111, 32'h12345678, 2'b00, 9'd0, 9'd0);
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b00, 9'd0, 9'd0);
    prevRdw = modelRdw;
    drive(1'b1, 9'd7, 4'b0011, 32'hFFFFFFFF, 2'b11, 9'd7, 9'd7);
    checkCount++; if (aRdata !== {2{32'h1234FFFF}}) $display("[TB] FAIL rdw_fwd: got %h expected 1234ffff1234ffff", aRdata); else passCount++;
    checkCount++; if (bRdata !== {2{32'h12345678}}) $display("[TB] FAIL rdw_old: got %h expected 1234567812345678", bRdata); else passCount++;
    checkCount++; if (aRdwCnt !== 16'(prevRdw + 2)) $display("[TB] FAIL rdw_cnt_plus2: got %0d expected %0d", aRdwCnt, prevRdw + 2); else passCount++;
    checkCount++; if (bRdwCnt !== 16'(modelRdw)) $display("[TB] FAIL rdw_cnt_b: got %0d expected %0d", bRdwCnt, modelRdw); else passCount++;
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b01, 9'd7, 9'd0);
    checkCount++; if (bRdata[31:0] !== 32'h1234FFFF) $display("[TB] FAIL raw_after_rdw_b: got %h expected 1234ffff", bRdata[31:0]); else passCount++;
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 9'd0, 4'b1111, 32'hCAFEF00D, 2'b00, 9'd0, 9'd0);
    drive(1'b1, 9'd510, 4'b1111, 32'hDEADBEEF, 2'b00, 9'd0, 9'd0);
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b11, 9'd510, 9'd0);
    checkCount++; if (cRvalid !== 2'b11) $display("[TB] FAIL oor_rvalid: got %b expected 11", cRvalid); else passCount++;
    checkCount++; if (cRdata[31:0] !== 32'h0) $display("[TB] FAIL oor_rdata: got %h expected 0", cRdata[31:0]); else passCount++;
    checkCount++; if (cRdata[63:32] !== 32'hCAFEF00D) $display("[TB] FAIL oor_addr0_intact: got %h expected cafef00d", cRdata[63:32]); else passCount++;
    // Instance C saw every in-range collision A saw; the one at 510 below is not one.
    drive(1'b1, 9'd510, 4'b1111, 32'h1, 2'b01, 9'd510, 9'd0);
    checkCount++; if (cRdwCnt !== 16'(modelRdw - 1)) $display("[TB] FAIL oor_no_collision: got %0d expected %0d", cRdwCnt, modelRdw - 1); else passCount++;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom, 2'($urandom_range(0, 3)), 9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)));
    end
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b00, 9'd0, 9'd0);
    checkCount++; if (aRdwCnt !== 16'(modelRdw)) $display("[TB] FAIL b2b_rdw_cnt: got %0d expected %0d", aRdwCnt, modelRdw); else passCount++;
  endtask

  task automatic test_reset_mid_fill();
    int rise = -1;
    drive(1'b1, 9'd300, 4'b1111, 32'h5A5A5A5A, 2'b00, 9'd0, 9'd0);
    ren = 2'b01; raddr = {9'd0, 9'd300};
    rst = 1'b1;
    modelReady = 1'b0;
    tick();
    checkCount++; if (aRvalid !== 2'b00) $display("[TB] FAIL inflight_dropped: got %b expected 00", aRvalid); else passCount++;
    ren = 2'b00;
    rst = 1'b0;
    for (int n = 0; n < 100; n++) tick();
    rst = 1'b1;
    #1;
    checkCount++; if (aInitDone !== 1'b0 || aRdwCnt !== 16'h0) $display("[TB] FAIL mid_fill_reset: got %b/%0d expected 0/0", aInitDone, aRdwCnt); else passCount++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 512; i++) model[i] = 32'h0;
    modelRdw = 0;
    for (int n = 1; n <= 700 && rise < 0; n++) begin
      tick();
      if (aInitDone === 1'b1) rise = n;
    end
    checkCount++; if (rise !== 512) $display("[TB] FAIL refill_latency: got %0d expected 512", rise); else passCount++;
    modelReady = 1'b1;
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b11, 9'd300, 9'd5);
    checkCount++; if (aRdata !== 64'h0) $display("[TB] FAIL refill_cleared: got %h expected 0", aRdata); else passCount++;
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 65534; n++) drive(1'b1, 9'd1, 4'b0000, 32'h0, 2'b01, 9'd1, 9'd0);
    checkCount++; if (aRdwCnt !== 16'hFFFE) $display("[TB] FAIL sat_fffe: got %h expected fffe", aRdwCnt); else passCount++;
    drive(1'b1, 9'd1, 4'b0000, 32'h0, 2'b11, 9'd1, 9'd1);
    checkCount++; if (aRdwCnt !== 16'hFFFF) $display("[TB] FAIL sat_clamp: got %h expected ffff", aRdwCnt); else passCount++;
    for (int n = 0; n < 4464; n++) drive(1'b1, 9'd1, 4'b0000, 32'h0, 2'b01, 9'd1, 9'd0);
    checkCount++; if (aRdwCnt !== 16'hFFFF) $display("[TB] FAIL sat_hold: got %h expected ffff", aRdwCnt); else passCount++;
    drive(1'b0, 9'd0, 4'h0, 32'h0, 2'b00, 9'd0, 9'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) model[i] = 32'h0;
    test_reset();
    test_fill();
    test_masked_write();
    test_rdw();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_fill();
    test_saturation();
    tick();
    #2;
    checkCount++;
    if (expQ0.size() != 0 || expQ1.size() != 0)
      $display("[TB] FAIL missing_reads: got %0d/%0d outstanding expected 0/0", expQ0.size(), expQ1.size());
    else
      passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
